// File: rtl/hs32_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hs32_alu_seq : handshaked execute-stage ALU, single-cycle ops plus an  |
// |                iterative MUL_STEP-bits-per-cycle multiplier, NZCV reg. |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module hs32_alu_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic             cen_i,
  input  logic             fwe_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic [3:0]       flags_o,
  output logic             busy_o
);

  localparam int c_SH_W  = $clog2(WIDTH);
  localparam int c_STEPS = WIDTH / MUL_STEP;
  localparam int c_CNT_W = $clog2(c_STEPS + 1);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_MUL = 3'b101;
  localparam logic [2:0] c_OP_SHL = 3'b110;
  localparam logic [2:0] c_OP_SHR = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_valid;
  logic [WIDTH-1:0]   r_res;
  logic [3:0]         r_flags;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic               r_fwe;

  logic               w_accept;
  logic               w_ci;
  logic [WIDTH-1:0]   w_bop;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic [WIDTH-1:0]   w_part;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic               w_last;

  assign ready_o  = (r_state == S_IDLE) && (!r_valid || ready_i) && !flush_i;
  assign w_accept = valid_i && ready_o;
  assign valid_o  = r_valid;
  assign res_o    = r_res;
  assign flags_o  = r_flags;
  assign busy_o   = (r_state == S_MUL);

  // SUB is a + ~b + ci, so the same adder serves both; C is taken from the flag register.
  always_comb begin
    w_bop = (op_i == c_OP_SUB) ? ~b_i : b_i;
    w_ci  = (op_i == c_OP_SUB) ? (cen_i ? r_flags[1] : 1'b1) : (cen_i & r_flags[1]);
    {w_cout, w_sum} = {1'b0, a_i} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_ci};
  end

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (op_i)
      c_OP_ADD, c_OP_SUB: begin
        w_alu_res = w_sum;
        w_alu_c   = w_cout;
        w_alu_v   = (a_i[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      c_OP_AND: w_alu_res = a_i & b_i;
      c_OP_OR:  w_alu_res = a_i | b_i;
      c_OP_XOR: w_alu_res = a_i ^ b_i;
      c_OP_SHL: w_alu_res = a_i << b_i[c_SH_W-1:0];
      c_OP_SHR: w_alu_res = a_i >> b_i[c_SH_W-1:0];
      default:  w_alu_res = '0;
    endcase
  end

  // One multiplier step: add the MUL_STEP shifted partial products selected by the low multiplier bits.
  always_comb begin
    w_part = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (r_mplier[j]) begin
        w_part = w_part + (r_mcand << j);
      end
    end
    w_acc_nxt = r_acc + w_part;
    w_last    = (r_cnt == c_CNT_W'(c_STEPS - 1));
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && (op_i == c_OP_MUL)) w_state_nxt = S_MUL;
        S_MUL:   if (w_last) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_flags  <= '0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_fwe    <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        if (op_i == c_OP_MUL) begin
          r_mcand  <= a_i;
          r_mplier <= b_i;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_fwe    <= fwe_i;
        end else begin
          r_res   <= w_alu_res;
          r_valid <= 1'b1;
          if (fwe_i) begin
            r_flags <= {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
          end
        end
      end
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << MUL_STEP;
        r_mplier <= r_mplier >> MUL_STEP;
        r_cnt    <= r_cnt + c_CNT_W'(1);
        if (w_last) begin
          r_res   <= w_acc_nxt;
          r_valid <= 1'b1;
          r_cnt   <= '0;
          if (r_fwe) begin
            r_flags <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), 1'b0, 1'b0};
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs32_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_hs32_alu_seq : scoreboard bench for hs32_alu_seq (32/1 and 16/4).   |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_hs32_alu_seq;

  localparam longint c_SMAX = 64'sd2147483647;
  localparam longint c_SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i, valid_i, cen_i, fwe_i, ready_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] res_o;
  logic [3:0]  flags_o;

  logic        flush2, valid2, cen2, fwe2, ready2;
  logic [2:0]  op2;
  logic [15:0] a2, b2;
  logic        ready2_o, valid2_o, busy2_o;
  logic [15:0] res2_o;
  logic [3:0]  flags2_o;

  always #5 clk = ~clk;

  hs32_alu_seq #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .cen_i(cen_i), .fwe_i(fwe_i), .a_i(a_i), .b_i(b_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .flags_o(flags_o), .busy_o(busy_o)
  );

  hs32_alu_seq #(.WIDTH(16), .MUL_STEP(4)) dut2 (
    .clk(clk), .reset(reset), .flush_i(flush2), .valid_i(valid2), .ready_o(ready2_o),
    .op_i(op2), .cen_i(cen2), .fwe_i(fwe2), .a_i(a2), .b_i(b2),
    .valid_o(valid2_o), .ready_i(ready2), .res_o(res2_o), .flags_o(flags2_o), .busy_o(busy2_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  m_flags;
  logic [31:0] last_res;
  logic [3:0]  last_flags;
  logic        rdy_mode  = 1'b1;
  logic        rdy_force = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values, flags from their definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cen, input logic fwe, input logic [3:0] fl);
    exp_t        e;
    longint      ua, ub, sa, sbv, full, sv, ci;
    logic [63:0] p;
    logic [31:0] r;
    logic        c, v;
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        ci = (cen && fl[1]) ? 1 : 0;
        full = ua + ub + ci;
        r = full[31:0];
        c = full[32];
        sv = sa + sbv + ci;
        v = (sv > c_SMAX) || (sv < c_SMIN);
      end
      3'd1: begin
        ci = cen ? (fl[1] ? 1 : 0) : 1;
        full = ua - ub - (1 - ci);
        r = full[31:0];
        c = (full >= 0);
        sv = sa - sbv - (1 - ci);
        v = (sv > c_SMAX) || (sv < c_SMIN);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
      end
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    e.res   = r;
    e.flags = fwe ? {r[31], (r == 32'd0), c, v} : fl;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    ready_i = rdy_mode ? rdy_force : ($urandom_range(0, 9) < 7);
  end

  // Monitor: pops on every result handshake and checks hold stability.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_flags;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (valid_o) begin
        if (prev_hold) begin
          chk("hold res stable", res_o, prev_res);
          chk("hold flags stable", flags_o, prev_flags);
        end
        if (ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected result", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res", res_o, e.res);
            chk("flags", flags_o, e.flags);
            last_res   = res_o;
            last_flags = flags_o;
          end
        end
      end
      prev_hold  = valid_o && !ready_i;
      prev_res   = res_o;
      prev_flags = flags_o;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cen, input logic fwe);
    exp_t e;
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; cen_i = cen; fwe_i = fwe;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (ready_o) begin
        e = model(op, a, b, cen, fwe, m_flags);
        m_flags = e.flags;
        sb.push_back(e);
        @(posedge clk); #1;
        valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("issue timeout", 0, 1);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain timeout", sb.size(), 0);
  endtask

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c, bad;
    logic [3:0]  f0;
    logic [31:0] x, y;
    reset = 1'b1; flush_i = 0; valid_i = 0; cen_i = 0; fwe_i = 0; op_i = 0; a_i = 0; b_i = 0;
    ready_i = 1'b1;
    flush2 = 0; valid2 = 0; cen2 = 0; fwe2 = 0; op2 = 0; a2 = 0; b2 = 0; ready2 = 1'b1;
    m_flags = 4'h0;
    #3;
    chk("reset valid_o", valid_o, 0);
    chk("reset res_o", res_o, 0);
    chk("reset flags_o", flags_o, 0);
    chk("reset busy_o", busy_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Signed overflow into the sign bit.
    issue(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    wait_drain();
    chk("t1 res", last_res, 32'h8000_0000);
    chk("t1 flags", last_flags, 4'b1001);

    // Equal SUB sets Z and C; the following ADD consumes C as carry-in.
    issue(3'd1, 32'd5, 32'd5, 1'b0, 1'b1);
    wait_drain();
    chk("t2 sub res", last_res, 32'd0);
    chk("t2 sub flags", last_flags, 4'b0110);
    issue(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    wait_drain();
    chk("t2 add res", last_res, 32'd1);
    chk("t2 add flags", last_flags, 4'b0110);

    // MUL latency and busy/ready during the iteration.
    issue(3'd5, 32'h0001_0003, 32'h0000_0005, 1'b0, 1'b1);
    c = 0; bad = 0;
    while (!valid_o && c < 40) begin
      if (!busy_o || ready_o) bad++;
      next_cycle(1);
      c++;
    end
    chk("t3 mul latency", c, 32);
    chk("t3 busy/ready during mul", bad, 0);
    wait_drain();
    chk("t3 mul res", last_res, 32'h0005_000F);

    // Backpressure: a held result blocks the next op until the consumer takes it.
    rdy_force = 1'b0;
    next_cycle(1);
    issue(3'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    fork
      issue(3'd4, 32'hA5A5_0F0F, 32'hFFFF_0000, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("t4 ready_o while held", ready_o, 0);
          next_cycle(1);
        end
        #1;
        rdy_force = 1'b1;
      end
    join
    wait_drain();
    chk("t4 xor res", last_res, 32'h5A5A_0F0F);

    // Flush at MUL step 10.
    f0 = m_flags;
    issue(3'd5, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
    next_cycle(9);
    flush_i = 1'b1;
    void'(sb.pop_back());
    m_flags = f0;
    next_cycle(1);
    flush_i = 1'b0;
    #1;
    chk("t5 valid after flush", valid_o, 0);
    chk("t5 busy after flush", busy_o, 0);
    chk("t5 ready after flush", ready_o, 1);
    chk("t5 flags after flush", flags_o, f0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid_o) bad++;
      next_cycle(1);
    end
    chk("t5 no late result", bad, 0);

    // Randomized traffic with random backpressure.
    rdy_mode = 1'b0;
    for (int i = 0; i < 250; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom), 1'($urandom));
    end
    wait_drain();
    rdy_mode = 1'b1;
    rdy_force = 1'b1;
    next_cycle(1);

    // 16-bit, 4-bits-per-step instance.
    for (int i = 0; i < 12; i++) begin
      x = $urandom; y = $urandom;
      op2 = (i % 2 == 0) ? 3'd5 : 3'd0;
      a2 = x[15:0]; b2 = y[15:0]; valid2 = 1'b1;
      c = 0;
      #1;
      while (!ready2_o && c < 20) begin next_cycle(1); #1; c++; end
      next_cycle(1);
      valid2 = 1'b0;
      c = 0;
      while (!valid2_o && c < 20) begin next_cycle(1); c++; end
      chk("w16 latency", c, (op2 == 3'd5) ? 4 : 0);
      chk("w16 res", res2_o, (op2 == 3'd5) ? 16'(x[15:0] * y[15:0]) : 16'(x[15:0] + y[15:0]));
      next_cycle(1);
    end
    chk("w16 flags untouched", flags2_o, 0);

    // Async reset in the middle of a MUL on both instances.
    fork
      issue(3'd5, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b1);
      begin
        op2 = 3'd5; a2 = 16'h00FF; b2 = 16'h00FF; valid2 = 1'b1;
        next_cycle(1);
        valid2 = 1'b0;
      end
    join
    next_cycle(2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6 mul valid_o", valid_o, 0);
    chk("t6 mul res_o", res_o, 0);
    chk("t6 mul flags_o", flags_o, 0);
    chk("t6 mul busy_o", busy_o, 0);
    chk("t6 w16 busy_o", busy2_o, 0);
    chk("t6 w16 res_o", res2_o, 0);
    sb.delete();
    m_flags = 4'h0;
    next_cycle(1);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid_o || valid2_o) bad++;
      next_cycle(1);
    end
    chk("t6 no result after reset", bad, 0);

    // Async reset while a result is held.
    rdy_force = 1'b0;
    next_cycle(1);
    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    next_cycle(1);
    chk("t6 hold valid before reset", valid_o, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6 hold valid_o", valid_o, 0);
    chk("t6 hold res_o", res_o, 0);
    chk("t6 hold flags_o", flags_o, 0);
    sb.delete();
    m_flags = 4'h0;
    next_cycle(1);
    reset = 1'b0;
    next_cycle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
